// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, shift, rotate, clear,
// with complementary outputs and a saturating shift counter.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [2:0]       mode_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qbar_out,
  output logic             so_left_out,
  output logic             so_right_out,
  output logic [CW-1:0]    cnt_out,
  output logic             done_out
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift;

  // Next register value and counter from the selected operation.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    shift = 1'b0;
    unique case (mode_in)
      M_HOLD: ;
      M_SHL: begin
        q_d   = {q_q[WIDTH-2:0], sl_in};
        shift = 1'b1;
      end
      M_SHR: begin
        q_d   = {sr_in, q_q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_LOAD: begin
        q_d   = d_in;
        cnt_d = '0;
      end
      M_ROL: begin
        q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift = 1'b1;
      end
      M_ROR: begin
        q_d   = {q_q[0], q_q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_ASR: begin
        q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_CLEAR: begin
        q_d   = RST_VAL;
        cnt_d = '0;
      end
    endcase
    if (shift && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (!en_in) begin
      q_d   = q_q;
      cnt_d = cnt_q;
    end
  end

  // Storage flops with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q_q   <= RST_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_out        = q_q;
  assign qbar_out     = ~q_q;
  assign so_left_out  = q_q[WIDTH-1];
  assign so_right_out = q_q[0];
  assign cnt_out      = cnt_q;
  assign done_out     = (cnt_q == CNT_MAX);

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised WIDTH-bit universal register built from D flip-flop storage. It is the clocked, multi-bit successor to the single-bit gated D latch.
- Supports hold, parallel load, logical and arithmetic shift, rotate and clear, with serial in/out at both ends.
- Provides complementary q_out/qbar_out outputs.
- Includes a shift counter and done flag so the block serves as a parallel-to-serial and serial-to-parallel converter in lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RST_VAL, 0, register value loaded on reset and on CLEAR mode; WIDTH bits.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- en_in  input  1  clock enable; when 0, all state holds regardless of mode_in.
- mode_in  input  3  operation select; encoding is listed under Behaviour.
- d_in  input  WIDTH  parallel load data.
- sl_in  input  1  serial input entering at the LSB on a left shift.
- sr_in  input  1  serial input entering at the MSB on a right shift.
- q_out  output  WIDTH  register contents.
- qbar_out  output  WIDTH  bitwise complement of q_out.
- so_left_out  output  1  equals q_out[WIDTH-1]; this is the bit that leaves on a left shift.
- so_right_out  output  1  equals q_out[0]; this is the bit that leaves on a right shift.
- cnt_out  output  $clog2(WIDTH+1)  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- done_out  output  1  high when cnt_out == WIDTH.

Behaviour:
- Reset (rst_in=1 at a rising edge): q_out<=RST_VAL and cnt_out<=0. Consequently qbar_out=~RST_VAL, done_out=0, and so_left_out/so_right_out follow RST_VAL. Reset overrides en_in and mode_in.
- en_in=0: q_out and cnt_out hold.
- mode_in encoding (applies when en_in=1), with the next-state of q:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], sl_in}.
  - 010 SHR: q <= {sr_in, q[WIDTH-1:1]}.
  - 011 LOAD: q <= d_in.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sr_in is ignored.
  - 111 CLEAR: q <= RST_VAL.
- Counter rules:
  - LOAD and CLEAR set cnt<=0.
  - SHL, SHR, ROL, ROR and ASR set cnt<=min(cnt+1, WIDTH).
  - HOLD leaves cnt unchanged.
  - done_out is combinational from cnt.
- Latency: one cycle. The new q is visible after the rising edge on which the operation is sampled.
- Output timing: qbar_out, so_left_out and so_right_out are purely combinational from q; there is no extra register stage.
- Continued shifting: shifting past WIDTH operations continues to move data normally; only cnt saturates, and done_out stays high.
- Simultaneous load and done: a LOAD issued in the same cycle that done_out=1 clears cnt, so done_out=0 on the next cycle.
- Control inputs are sampled only at the clock edge. Glitches between edges have no effect, unlike the transparent latch.
- Reset mid-operation: a reset asserted during a shift sequence aborts it. The next cycle shows RST_VAL and cnt=0.

Test Plan:
- Reset check (WIDTH=8, RST_VAL=0): assert rst_in for 1 cycle with mode_in=011, d_in=8'hFF -> q_out=8'h00, qbar_out=8'hFF, cnt_out=0, done_out=0.
- Load then hold: LOAD d_in=8'hA5; then en_in=0 with mode_in=001 for 3 cycles -> q_out=8'hA5 throughout, cnt_out=0.
- Parallel-to-serial: LOAD 8'hB4, then 8 cycles of SHR with sr_in=0:
  - so_right_out sampled before each edge gives 0,0,1,0,1,1,0,1.
  - After the 8th shift: q_out=8'h00, cnt_out=8, done_out=1.
  - A 9th SHR keeps cnt_out=8.
- Serial-to-parallel and rotate: from q_out=8'h00, 8 SHL cycles with sl_in sequence 1,0,1,1,0,0,1,0 -> q_out=8'hB2, done_out=1. Then one ROL -> q_out=8'h65; one ROR -> 8'hB2.
- Arithmetic shift: LOAD 8'h90, then 2 ASR with sr_in=0 -> q_out=8'hC8 then 8'hE4, cnt_out=2.
- Mid-sequence reset and clear:
  - LOAD 8'h3C, 3 SHL, then rst_in=1 for 1 cycle -> q_out=0, cnt_out=0.
  - Repeat with RST_VAL=8'h0F using CLEAR instead of reset -> q_out=8'h0F, qbar_out=8'hF0, cnt_out=0.
